// File: rtl/distribuidor_gerador.sv
// distribuidor_gerador
// Splits coordinate packets arriving from the ESP serial link between the two
// move generators. A packet is three bytes: HEADER, a coordinate byte
// {numGerador, reserved(0), linha[2:0], coluna[2:0]} and a check byte equal to
// HEADER ^ coordinate. Framing, reserved bit, checksum and inter-byte timeout
// are validated; good packets update only the addressed generator's outputs.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   dado[7:0], dadoValido   received byte and its one-cycle strobe
//   linhaGen1/colunaGen1    last coordinates delivered to generator 1
//   validoGen1              one-cycle pulse on delivery to generator 1
//   linhaGen2/colunaGen2    last coordinates delivered to generator 2
//   validoGen2              one-cycle pulse on delivery to generator 2
//   erroPacote              one-cycle pulse on a rejected packet
//   ocupado                 high while a packet is in progress
module distribuidor_gerador #(
  parameter logic [7:0] HEADER         = 8'hA5,
  parameter int         TIMEOUT_CICLOS = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] dado,
  input  logic       dadoValido,
  output logic [2:0] linhaGen1,
  output logic [2:0] colunaGen1,
  output logic       validoGen1,
  output logic [2:0] linhaGen2,
  output logic [2:0] colunaGen2,
  output logic       validoGen2,
  output logic       erroPacote,
  output logic       ocupado
);

  localparam int CW = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
  // The timeout fires on the edge at which the idle count would reach
  // TIMEOUT_CICLOS-1, i.e. after TIMEOUT_CICLOS-1 consecutive idle cycles.
  localparam logic [CW-1:0] CONT_LIMITE = CW'(TIMEOUT_CICLOS - 2);

  typedef enum logic [1:0] {
    ESPERA_CAB   = 2'd0,
    ESPERA_COORD = 2'd1,
    ESPERA_CHECK = 2'd2
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [CW-1:0] cont_q, cont_d;
  logic [7:0]    coord_q, coord_d;
  logic [2:0]    linha1_q, linha1_d, coluna1_q, coluna1_d;
  logic [2:0]    linha2_q, linha2_d, coluna2_q, coluna2_d;
  logic          valido1_q, valido1_d, valido2_q, valido2_d;
  logic          erro_q, erro_d;

  always_comb begin
    estado_d  = estado_q;
    cont_d    = '0;          // cleared on every byte and whenever a packet ends
    coord_d   = coord_q;
    linha1_d  = linha1_q;
    coluna1_d = coluna1_q;
    linha2_d  = linha2_q;
    coluna2_d = coluna2_q;
    valido1_d = 1'b0;
    valido2_d = 1'b0;
    erro_d    = 1'b0;

    case (estado_q)
      ESPERA_CAB: begin
        // Non-header bytes between packets are line noise: dropped silently.
        if (dadoValido && (dado == HEADER)) begin
          estado_d = ESPERA_COORD;
        end
      end

      ESPERA_COORD: begin
        if (dadoValido) begin
          coord_d = dado;
          if (dado[6]) begin
            erro_d   = 1'b1;
            estado_d = ESPERA_CAB;
          end else begin
            estado_d = ESPERA_CHECK;
          end
        end else if (cont_q == CONT_LIMITE) begin
          erro_d   = 1'b1;
          estado_d = ESPERA_CAB;
        end else begin
          cont_d = cont_q + 1'b1;
        end
      end

      ESPERA_CHECK: begin
        // A byte on the expiry edge wins over the timeout.
        if (dadoValido) begin
          estado_d = ESPERA_CAB;
          if (dado == (HEADER ^ coord_q)) begin
            if (coord_q[7]) begin
              linha2_d  = coord_q[5:3];
              coluna2_d = coord_q[2:0];
              valido2_d = 1'b1;
            end else begin
              linha1_d  = coord_q[5:3];
              coluna1_d = coord_q[2:0];
              valido1_d = 1'b1;
            end
          end else begin
            erro_d = 1'b1;
          end
        end else if (cont_q == CONT_LIMITE) begin
          erro_d   = 1'b1;
          estado_d = ESPERA_CAB;
        end else begin
          cont_d = cont_q + 1'b1;
        end
      end

      default: begin
        estado_d = ESPERA_CAB;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= ESPERA_CAB;
      cont_q    <= '0;
      coord_q   <= '0;
      linha1_q  <= '0;
      coluna1_q <= '0;
      linha2_q  <= '0;
      coluna2_q <= '0;
      valido1_q <= 1'b0;
      valido2_q <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cont_q    <= cont_d;
      coord_q   <= coord_d;
      linha1_q  <= linha1_d;
      coluna1_q <= coluna1_d;
      linha2_q  <= linha2_d;
      coluna2_q <= coluna2_d;
      valido1_q <= valido1_d;
      valido2_q <= valido2_d;
      erro_q    <= erro_d;
    end
  end

  assign linhaGen1  = linha1_q;
  assign colunaGen1 = coluna1_q;
  assign validoGen1 = valido1_q;
  assign linhaGen2  = linha2_q;
  assign colunaGen2 = coluna2_q;
  assign validoGen2 = valido2_q;
  assign erroPacote = erro_q;
  // Decoded straight from the state register, so still a registered output.
  assign ocupado    = (estado_q != ESPERA_CAB);

endmodule

// File: tb/tb_distribuidor_gerador.sv
module tb_distribuidor_gerador;

  localparam logic [7:0] HDR = 8'hA5;
  localparam int         TMO = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] dado = 8'h00;
  logic       dadoValido = 1'b0;
  logic [2:0] linhaGen1, colunaGen1, linhaGen2, colunaGen2;
  logic       validoGen1, validoGen2, erroPacote, ocupado;

  int errors = 0;
  int checks = 0;

  distribuidor_gerador #(.HEADER(HDR), .TIMEOUT_CICLOS(TMO)) dut (
    .clock(clock), .reset(reset), .dado(dado), .dadoValido(dadoValido),
    .linhaGen1(linhaGen1), .colunaGen1(colunaGen1), .validoGen1(validoGen1),
    .linhaGen2(linhaGen2), .colunaGen2(colunaGen2), .validoGen2(validoGen2),
    .erroPacote(erroPacote), .ocupado(ocupado)
  );

  always #5 clock = ~clock;

  // Observed outputs packed as {v1,l1,c1,v2,l2,c2,err,busy}.
  logic [15:0] obs;
  assign obs = {validoGen1, linhaGen1, colunaGen1, validoGen2, linhaGen2,
                colunaGen2, erroPacote, ocupado};

  // Reference model: the packet so far is a list of collected bytes, plus a
  // count of idle cycles since the last byte.
  logic [7:0] pkt[$];
  int         idle;
  logic [2:0] m_l1, m_c1, m_l2, m_c2;
  logic       m_v1, m_v2, m_err, m_busy;

  task automatic model_clear();
    pkt.delete();
    idle = 0;
    m_l1 = 0; m_c1 = 0; m_l2 = 0; m_c2 = 0;
    m_v1 = 0; m_v2 = 0; m_err = 0; m_busy = 0;
  endtask

  task automatic model_edge(input logic v, input logic [7:0] b);
    logic [7:0] c;
    m_v1 = 0; m_v2 = 0; m_err = 0;
    if (v) begin
      idle = 0;
      if (pkt.size() == 0) begin
        if (b == HDR) pkt.push_back(b);
      end else if (pkt.size() == 1) begin
        if (b[6]) begin m_err = 1; pkt.delete(); end
        else pkt.push_back(b);
      end else begin
        c = pkt[1];
        if ((pkt[0] ^ c) == b) begin
          if (c >= 8'd128) begin m_v2 = 1; m_l2 = 3'((c / 8) % 8); m_c2 = 3'(c % 8); end
          else begin m_v1 = 1; m_l1 = 3'((c / 8) % 8); m_c1 = 3'(c % 8); end
        end else begin
          m_err = 1;
        end
        pkt.delete();
      end
    end else if (pkt.size() != 0) begin
      idle++;
      if (idle == TMO - 1) begin m_err = 1; pkt.delete(); idle = 0; end
    end
    m_busy = (pkt.size() != 0);
  endtask

  // Drive one cycle (byte or idle), then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic [7:0] b);
    dadoValido = v;
    dado = b;
    @(posedge clock);
    model_edge(v, b);
    #1;
    dadoValido = 1'b0;
    dado = 8'($urandom);
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (obs !== 16'h0000) begin
      errors++; $display("FAIL reset_state got=%h exp=%h", obs, 16'h0000);
    end
    release_reset();
    checks++;
    if (obs !== 16'h0000) begin
      errors++; $display("FAIL post_reset_idle got=%h exp=%h", obs, 16'h0000);
    end
  endtask

  task automatic test_gen1();
    logic [15:0] e;
    step(1, HDR);
    e = {1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1};
    checks++; if (obs !== e) begin errors++; $display("FAIL gen1_hdr got=%h exp=%h", obs, e); end
    step(1, 8'h1D);
    step(1, 8'hB8);
    e = {1'b1, 3'd3, 3'd5, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0};
    checks++; if (obs !== e) begin errors++; $display("FAIL gen1_deliver got=%h exp=%h", obs, e); end
    step(0, 8'h00);
    e = {1'b0, 3'd3, 3'd5, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0};
    checks++; if (obs !== e) begin errors++; $display("FAIL gen1_pulse_end got=%h exp=%h", obs, e); end
  endtask

  task automatic test_gen2_junk();
    logic [15:0] e;
    step(1, 8'h00);
    step(1, 8'h7F);
    e = {1'b0, 3'd3, 3'd5, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0};
    checks++; if (obs !== e) begin errors++; $display("FAIL junk_ignored got=%h exp=%h", obs, e); end
    step(1, HDR);
    step(1, 8'hB8);
    step(1, 8'h1D);
    e = {1'b0, 3'd3, 3'd5, 1'b1, 3'd7, 3'd0, 1'b0, 1'b0};
    checks++; if (obs !== e) begin errors++; $display("FAIL gen2_deliver got=%h exp=%h", obs, e); end
  endtask

  task automatic test_bad_checksum();
    logic [15:0] e;
    step(1, HDR); step(1, 8'h1D); step(1, 8'hB9);
    e = {1'b0, 3'd3, 3'd5, 1'b0, 3'd7, 3'd0, 1'b1, 1'b0};
    checks++; if (obs !== e) begin errors++; $display("FAIL bad_cksum got=%h exp=%h", obs, e); end
    step(1, HDR);
    e = {1'b0, 3'd3, 3'd5, 1'b0, 3'd7, 3'd0, 1'b0, 1'b1};
    checks++; if (obs !== e) begin errors++; $display("FAIL bad_cksum_single got=%h exp=%h", obs, e); end
    step(1, 8'h12); step(1, 8'hB7);
    e = {1'b1, 3'd2, 3'd2, 1'b0, 3'd7, 3'd0, 1'b0, 1'b0};
    checks++; if (obs !== e) begin errors++; $display("FAIL after_bad_cksum got=%h exp=%h", obs, e); end
  endtask

  task automatic test_reserved_bit();
    logic [15:0] e;
    step(1, HDR); step(1, 8'h40);
    e = {1'b0, 3'd2, 3'd2, 1'b0, 3'd7, 3'd0, 1'b1, 1'b0};
    checks++; if (obs !== e) begin errors++; $display("FAIL reserved_err got=%h exp=%h", obs, e); end
    step(1, HDR);
    e = {1'b0, 3'd2, 3'd2, 1'b0, 3'd7, 3'd0, 1'b0, 1'b1};
    checks++; if (obs !== e) begin errors++; $display("FAIL reserved_restart got=%h exp=%h", obs, e); end
    step(1, 8'h1D); step(1, 8'hB8);
    e = {1'b1, 3'd3, 3'd5, 1'b0, 3'd7, 3'd0, 1'b0, 1'b0};
    checks++; if (obs !== e) begin errors++; $display("FAIL reserved_recover got=%h exp=%h", obs, e); end
  endtask

  task automatic test_timeout();
    logic [15:0] e;
    step(1, HDR);
    for (int i = 0; i < TMO - 2; i++) step(0, 8'h00);
    e = {1'b0, 3'd3, 3'd5, 1'b0, 3'd7, 3'd0, 1'b0, 1'b1};
    checks++; if (obs !== e) begin errors++; $display("FAIL timeout_early got=%h exp=%h", obs, e); end
    step(0, 8'h00);
    e = {1'b0, 3'd3, 3'd5, 1'b0, 3'd7, 3'd0, 1'b1, 1'b0};
    checks++; if (obs !== e) begin errors++; $display("FAIL timeout_fire got=%h exp=%h", obs, e); end
    // Byte lands exactly on the expiry edge: it is taken, no timeout.
    step(1, HDR);
    for (int i = 0; i < TMO - 2; i++) step(0, 8'h00);
    step(1, 8'h12);
    e = {1'b0, 3'd3, 3'd5, 1'b0, 3'd7, 3'd0, 1'b0, 1'b1};
    checks++; if (obs !== e) begin errors++; $display("FAIL timeout_byte_wins got=%h exp=%h", obs, e); end
    for (int i = 0; i < TMO - 2; i++) step(0, 8'h00);
    step(1, 8'hB7);
    e = {1'b1, 3'd2, 3'd2, 1'b0, 3'd7, 3'd0, 1'b0, 1'b0};
    checks++; if (obs !== e) begin errors++; $display("FAIL timeout_then_deliver got=%h exp=%h", obs, e); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    step(1, HDR); step(1, 8'h1D); step(1, 8'hB8);
    step(1, HDR);
    e = {1'b0, 3'd3, 3'd5, 1'b0, 3'd7, 3'd0, 1'b0, 1'b1};
    checks++; if (obs !== e) begin errors++; $display("FAIL b2b_hdr got=%h exp=%h", obs, e); end
    step(1, 8'h91); step(1, 8'h34);
    e = {1'b0, 3'd3, 3'd5, 1'b1, 3'd2, 3'd1, 1'b0, 1'b0};
    checks++; if (obs !== e) begin errors++; $display("FAIL b2b_gen2 got=%h exp=%h", obs, e); end
  endtask

  task automatic test_reset_mid_packet();
    logic [15:0] e;
    step(1, HDR); step(1, 8'h1D);
    reset = 1'b1;
    #2;
    checks++; if (obs !== 16'h0000) begin errors++; $display("FAIL mid_reset got=%h exp=%h", obs, 16'h0000); end
    release_reset();
    checks++; if (obs !== 16'h0000) begin errors++; $display("FAIL mid_reset_noerr got=%h exp=%h", obs, 16'h0000); end
    step(1, HDR); step(1, 8'h1D); step(1, 8'hB8);
    e = {1'b1, 3'd3, 3'd5, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0};
    checks++; if (obs !== e) begin errors++; $display("FAIL mid_reset_recover got=%h exp=%h", obs, e); end
  endtask

  task automatic test_random();
    logic [8:0]  stim[$];
    logic [7:0]  c, k;
    logic [15:0] e;
    int          kind, gap;
    for (int p = 0; p < 60; p++) begin
      kind = $urandom_range(0, 5);
      c = {1'($urandom), 1'b0, 6'($urandom)};
      k = HDR ^ c;
      gap = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 9) : $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) stim.push_back({1'b0, 8'h00});
      case (kind)
        0: stim.push_back({1'b1, 8'($urandom)});
        2: begin
          stim.push_back({1'b1, HDR}); stim.push_back({1'b1, c});
          stim.push_back({1'b1, k ^ (8'd1 << $urandom_range(0, 7))});
        end
        3: begin stim.push_back({1'b1, HDR}); stim.push_back({1'b1, c | 8'h40}); end
        4: begin
          stim.push_back({1'b1, HDR}); stim.push_back({1'b1, c});
          for (int g = 0; g < TMO; g++) stim.push_back({1'b0, 8'h00});
        end
        default: begin
          stim.push_back({1'b1, HDR});
          if ($urandom_range(0, 3) == 0) stim.push_back({1'b0, 8'h00});
          stim.push_back({1'b1, c}); stim.push_back({1'b1, k});
        end
      endcase
    end
    for (int i = 0; i < stim.size(); i++) begin
      step(stim[i][8], stim[i][7:0]);
      e = {m_v1, m_l1, m_c1, m_v2, m_l2, m_c2, m_err, m_busy};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL random_cycle%0d byte=%h vld=%0b got=%h exp=%h", i, stim[i][7:0], stim[i][8], obs, e);
      end
      checks++;
      if ((32'(validoGen1) + 32'(validoGen2) + 32'(erroPacote)) > 1) begin
        errors++;
        $display("FAIL random_exclusive cycle%0d got=%b%b%b exp=at most one", i, validoGen1, validoGen2, erroPacote);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_gen1();
    test_gen2_junk();
    test_bad_checksum();
    test_reserved_bit();
    test_timeout();
    test_back_to_back();
    test_reset_mid_packet();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/distribuidor_gerador.md
# distribuidor_gerador

Receives coordinate packets from the ESP link byte stream and delivers each decoded board square (linha, coluna) to one of the two move generators. It is the inbound counterpart of the generator selector: the selector merges the two generators' coordinates toward the ESP, and this block splits ESP-originated coordinates back to generator 1 or generator 2. It sits between the byte-level serial receiver and the two generator input ports, and validates packet framing, checksum and inter-byte timeout.

## Interface

Parameters:
- HEADER, 8'hA5, packet start byte.
- TIMEOUT_CICLOS, 50000, maximum idle cycles allowed between consecutive packet bytes. Must be ≥2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- dado  in  8  received byte from the serial receiver.
- dadoValido  in  1  one-cycle strobe; `dado` is sampled on the rising edge where this is high.
- linhaGen1  out  3  last delivered row for generator 1.
- colunaGen1  out  3  last delivered column for generator 1.
- validoGen1  out  1  one-cycle pulse when new coordinates are delivered to generator 1.
- linhaGen2  out  3  last delivered row for generator 2.
- colunaGen2  out  3  last delivered column for generator 2.
- validoGen2  out  1  one-cycle pulse when new coordinates are delivered to generator 2.
- erroPacote  out  1  one-cycle pulse on a rejected packet.
- ocupado  out  1  high while a packet is in progress, i.e. state ≠ ESPERA_CAB.

## Operation

- Packet format is 3 bytes:
  - Byte 0: HEADER.
  - Byte 1 (coordinate): bit7 = numGerador (0 → gen1, 1 → gen2); bit6 = reserved, must be 0; bits[5:3] = linha; bits[2:0] = coluna.
  - Byte 2 (check): must equal HEADER XOR byte1.
- FSM has 3 states:
  - ESPERA_CAB: a byte equal to HEADER moves the FSM to ESPERA_COORD. Any other byte is silently ignored, with no error.
  - ESPERA_COORD: the byte is stored in the coordinate register and the FSM moves to ESPERA_CHECK. If bit6 = 1, erroPacote pulses and the FSM returns to ESPERA_CAB.
  - ESPERA_CHECK:
    - On a checksum match, the selected generator's linha/coluna registers load from the stored byte, that generator's valido pulses, and the FSM goes to ESPERA_CAB.
    - On a mismatch, erroPacote pulses, no coordinate output changes, and the FSM goes to ESPERA_CAB.
- The non-selected generator's outputs are never modified by a packet.
- Inter-byte timeout:
  - A counter clears on every accepted byte while in ESPERA_COORD or ESPERA_CHECK, and on entry to those states.
  - It increments each cycle without dadoValido.
  - When it reaches TIMEOUT_CICLOS−1 with no byte that cycle, erroPacote pulses and the FSM goes to ESPERA_CAB.
  - The counter is held at 0 in ESPERA_CAB.
- A byte arriving on the same edge the timeout would fire takes precedence: it is processed and the timeout does not fire.
- A HEADER value received as byte 1 or byte 2 gets no special treatment; it is processed as data.

## Timing

- Reset (asynchronous): state = ESPERA_CAB, counter = 0. All outputs are 0: linhaGen1/2 = 0, colunaGen1/2 = 0, validoGen1/2 = 0, erroPacote = 0, ocupado = 0.
- Reset mid-packet aborts the packet with no erroPacote pulse.
- All outputs are registered; none is a combinational path from `dado`.
- Delivery latency:
  - The check byte is sampled on edge N.
  - linha/coluna for the target generator are updated and validoGen* is high in the cycle after edge N.
  - validoGen* deasserts after edge N+1.
- erroPacote follows the same timing, high for the cycle after the offending edge.
- Back-to-back packets are allowed. A HEADER sampled on edge N+1 (during the valido cycle) is accepted, so a 3-byte packet can complete every 3 byte strobes.
- dadoValido may be high on consecutive cycles; each high cycle is one byte.
- ocupado goes high the cycle after HEADER is sampled and low the cycle after the packet ends, whether delivered, errored or timed out.
- validoGen1, validoGen2 and erroPacote are mutually exclusive in any cycle.

## Test plan

- Gen1 delivery: bytes A5, 1D, B8 → one-cycle validoGen1 in the cycle after the B8 edge, with linhaGen1 = 3, colunaGen1 = 5. Gen2 outputs stay 0 and erroPacote stays 0.
- Gen2 delivery, with leading junk: bytes 00, 7F, A5, B8, 1D → the junk is ignored with no error; validoGen2 pulses, linhaGen2 = 7, colunaGen2 = 0, and gen1 values from the previous test are retained.
- Bad checksum: A5, 1D, B9 → erroPacote pulses once, no valido, all coordinates unchanged. A following valid packet A5, 12, B7 delivers linhaGen1 = 2, colunaGen1 = 2.
- Reserved bit set: A5, 40 → erroPacote pulses the cycle after the 40 edge and ocupado drops. A subsequent A5 restarts the packet normally.
- Timeout (TIMEOUT_CICLOS = 8): A5, then idle for 7 cycles → erroPacote pulses and ocupado drops. Repeat with the byte arriving exactly on the expiry cycle → no error, and the packet proceeds.
- Reset mid-packet: A5, 1D, then assert reset → all outputs 0 with no erroPacote. After release, A5, 1D, B8 delivers normally.
